// File: rtl/serial_add_sequencer.sv
// Bit-serial adder: one full_adder plus a carry flop processes WIDTH-bit operands LSB-first.
// Optional subtract mode is enabled by defining SERIAL_ADD_SUB_EN (adds a 'sub' input port).

module full_adder (
  input  logic a_in,
  input  logic b_in,
  input  logic c_in,
  output logic s_out,
  output logic c_out
);
  assign s_out = a_in ^ b_in ^ c_in;
  assign c_out = (a_in & b_in) | (c_in & (a_in ^ b_in));
endmodule

module serial_add_sequencer #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SERIAL_ADD_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);
  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_sh_q, a_sh_d;
  logic [WIDTH-1:0]   b_sh_q, b_sh_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               carry_q, carry_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               cout_q, cout_d;
  logic               ovf_q, ovf_d;
  logic               fa_s, fa_co;
  logic               sub_mode;
  logic [WIDTH-1:0]   b_load;
  logic               carry_load;

`ifdef SERIAL_ADD_SUB_EN
  assign sub_mode = sub;
`else
  assign sub_mode = 1'b0;
`endif

  // Subtraction is a + ~b + 1, so only the B load value and the initial carry change.
  assign b_load     = sub_mode ? ~b : b;
  assign carry_load = sub_mode ? 1'b1 : cin;

  full_adder u_fa (
    .a_in  (a_sh_q[0]),
    .b_in  (b_sh_q[0]),
    .c_in  (carry_q),
    .s_out (fa_s),
    .c_out (fa_co)
  );

  always_comb begin
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    busy_d  = busy_q;
    done_d  = done_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          a_sh_d  = a;
          b_sh_d  = b_load;
          carry_d = carry_load;
          cnt_d   = '0;
          sum_d   = '0;
          busy_d  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        sum_d   = {fa_s, sum_q[WIDTH-1:1]};
        a_sh_d  = a_sh_q >> 1;
        b_sh_d  = b_sh_q >> 1;
        carry_d = fa_co;
        cnt_d   = cnt_q + CNT_W'(1);
        // On the MSB, carry_q is the carry into the MSB and fa_co the carry out.
        if (cnt_q == LAST_BIT) begin
          cout_d  = fa_co;
          ovf_d   = carry_q ^ fa_co;
          done_d  = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        done_d  = 1'b0;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        done_d  = 1'b0;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign sum      = sum_q;
  assign cout     = cout_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_serial_add_sequencer.sv
// Randomized self-checking bench for serial_add_sequencer against an integer-arithmetic model.

module tb_serial_add_sequencer;
  localparam int W = 4;
`ifdef SERIAL_ADD_SUB_EN
  localparam bit HAS_SUB = 1'b1;
`else
  localparam bit HAS_SUB = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset, start, cin, sub;
  logic [W-1:0] a, b;
  logic         busy, done, cout, overflow;
  logic [W-1:0] sum;

  int n_cmp = 0;
  int n_bad = 0;

  serial_add_sequencer #(.WIDTH(W)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .a        (a),
    .b        (b),
    .cin      (cin),
`ifdef SERIAL_ADD_SUB_EN
    .sub      (sub),
`endif
    .busy     (busy),
    .done     (done),
    .sum      (sum),
    .cout     (cout),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Returns {overflow, cout, sum} from plain unsigned/signed integer arithmetic.
  function automatic logic [W+1:0] model(input logic [W-1:0] a_i, input logic [W-1:0] b_i,
                                         input logic c_i, input logic s_i);
    int ua, ub, sa, sb, r, sr;
    logic co, ov;
    logic [W-1:0] rs;
    ua = int'(a_i);
    ub = int'(b_i);
    sa = a_i[W-1] ? ua - (1 << W) : ua;
    sb = b_i[W-1] ? ub - (1 << W) : ub;
    if (s_i) begin
      r  = ua - ub;
      co = (ua >= ub);
      sr = sa - sb;
    end else begin
      r  = ua + ub + int'(c_i);
      co = (r >= (1 << W));
      sr = sa + sb + int'(c_i);
    end
    ov = (sr > ((1 << (W - 1)) - 1)) || (sr < -(1 << (W - 1)));
    rs = r[W-1:0];
    return {ov, co, rs};
  endfunction

  // One operation from IDLE: checks latency, busy length, single done pulse and results.
  task automatic do_op(input logic [W-1:0] a_i, input logic [W-1:0] b_i, input logic c_i,
                       input logic s_i, input bit poke);
    logic [W+1:0] exp;
    int busy_cnt, done_cnt, done_at;
    exp = model(a_i, b_i, c_i, s_i);
    a = a_i; b = b_i; cin = c_i; sub = s_i; start = 1'b1;
    step();
    start = 1'b0;
    a = W'($urandom); b = W'($urandom); cin = 1'($urandom); sub = HAS_SUB ? 1'($urandom) : 1'b0;
    busy_cnt = 0; done_cnt = 0; done_at = -1;
    for (int k = 0; k < W + 4; k++) begin
      if (busy) busy_cnt++;
      if (done) begin
        done_cnt++;
        done_at = k;
        check_eq("sum", sum, exp[W-1:0]);
        check_eq("cout", cout, exp[W]);
        check_eq("overflow", overflow, exp[W+1]);
      end
      start = (poke && k == 1);
      step();
    end
    check_eq("done_latency", done_at, W);
    check_eq("done_pulses", done_cnt, 1);
    check_eq("busy_cycles", busy_cnt, W + 1);
    check_eq("sum_hold", sum, exp[W-1:0]);
    $display("op a=%0h b=%0h cin=%0b sub=%0b -> sum=%0h cout=%0b ovf=%0b (model %0h %0b %0b)",
             a_i, b_i, c_i, s_i, sum, cout, overflow, exp[W-1:0], exp[W], exp[W+1]);
  endtask

  logic [W-1:0] qa[$], qb[$];
  logic         qc[$];

  initial begin
    logic [W+1:0] exp;
    int pulses, last_t, spurious;
    reset = 1'b1; start = 1'b1; a = '1; b = '1; cin = 1'b1; sub = 1'b0;

    // Reset held two cycles with start high.
    for (int i = 0; i < 2; i++) begin
      step();
      check_eq("rst_busy", busy, 0);
      check_eq("rst_done", done, 0);
      check_eq("rst_sum", sum, 0);
      check_eq("rst_cout", cout, 0);
      check_eq("rst_ovf", overflow, 0);
    end
    reset = 1'b0; start = 1'b0;
    step();

    do_op(4'h3, 4'h5, 1'b0, 1'b0, 1'b0);
    do_op(4'hF, 4'h1, 1'b1, 1'b0, 1'b1);
    do_op(4'hF, 4'hF, 1'b1, 1'b0, 1'b0);
    do_op(4'h0, 4'h0, 1'b0, 1'b0, 1'b0);

    // Reset in the middle of RUN aborts with no done pulse.
    a = 4'h7; b = 4'h6; cin = 1'b1; start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    check_eq("abort_busy", busy, 0);
    check_eq("abort_sum", sum, 0);
    check_eq("abort_done", done, 0);
    spurious = 0;
    for (int i = 0; i < W + 4; i++) begin
      if (done) spurious++;
      step();
    end
    check_eq("abort_no_done", spurious, 0);
    do_op(4'h2, 4'h2, 1'b0, 1'b0, 1'b0);

    if (HAS_SUB) begin
      do_op(4'h3, 4'h5, 1'b1, 1'b1, 1'b0);
      do_op(4'h8, 4'h1, 1'b0, 1'b1, 1'b0);
    end

    for (int i = 0; i < 20; i++)
      do_op(W'($urandom), W'($urandom), 1'($urandom),
            HAS_SUB ? 1'($urandom) : 1'b0, bit'($urandom_range(0, 1)));

    // Start held high: back-to-back ops, operands changed whenever done is seen.
    sub = 1'b0;
    a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
    qa.push_back(a); qb.push_back(b); qc.push_back(cin);
    start = 1'b1;
    pulses = 0; last_t = -1;
    for (int t = 0; t < 3 * (W + 2) + 10 && pulses < 3; t++) begin
      step();
      if (done) begin
        exp = model(qa.pop_front(), qb.pop_front(), qc.pop_front(), 1'b0);
        check_eq("held_sum", sum, exp[W-1:0]);
        check_eq("held_cout", cout, exp[W]);
        if (pulses > 0) check_eq("held_spacing", t - last_t, W + 2);
        $display("held op %0d: sum=%0h cout=%0b (model %0h %0b)", pulses, sum, cout,
                 exp[W-1:0], exp[W]);
        last_t = t;
        pulses++;
        if (pulses < 3) begin
          a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
          qa.push_back(a); qb.push_back(b); qc.push_back(cin);
        end else begin
          start = 1'b0;
        end
      end
    end
    start = 1'b0;
    check_eq("held_pulses", pulses, 3);
    spurious = 0;
    for (int i = 0; i < W + 4; i++) begin
      step();
      if (done) spurious++;
    end
    check_eq("held_drain", spurious, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
